// File: rtl/filterbank_sequencer_if.sv
// Sample-in / result-out bus of the filterbank sequencer.
// The master drives new samples and the result acknowledge; the slave (the
// sequencer) drives the delay-line, MAC and status controls.
interface filterbank_sequencer_if #(
    parameter int DW = 15
);
    logic                 enable;
    logic                 in_strobe;
    logic signed [DW-1:0] in_sample;
    logic                 out_ready;

    logic                 in_ready;
    logic                 shift_en;
    logic signed [DW-1:0] shift_data;
    logic [5:0]           phase;
    logic [6:0]           tap_a;
    logic [6:0]           tap_b;
    logic                 acc_clear;
    logic                 acc_en;
    logic                 center;
    logic                 out_valid;
    logic                 overrun;
    logic [15:0]          sample_count;

    modport master (
        output enable, in_strobe, in_sample, out_ready,
        input  in_ready, shift_en, shift_data, phase, tap_a, tap_b,
               acc_clear, acc_en, center, out_valid, overrun, sample_count
    );

    modport slave (
        input  enable, in_strobe, in_sample, out_ready,
        output in_ready, shift_en, shift_data, phase, tap_a, tap_b,
               acc_clear, acc_en, center, out_valid, overrun, sample_count
    );
endinterface

// File: rtl/filterbank_sequencer.sv
// Control sequencer for a symmetric-fold FIR filterbank.
// Per accepted sample: one delay-line shift, NUM_PHASES MAC phases walking
// the symmetric tap pairs inward to the center tap, then a result handshake.
// Samples arriving while busy are dropped and flagged in a sticky overrun.
module filterbank_sequencer #(
    parameter int NUM_TAPS   = 119,
    parameter int NUM_PHASES = 60,
    parameter int DW         = 15
) (
    input  logic                  clk_en,
    input  logic                  reset,
    filterbank_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_PHASE = 6'(NUM_PHASES - 1);
    localparam logic [6:0] LAST_TAP   = 7'(NUM_TAPS - 1);

    state_t               state_q, state_d;
    logic [5:0]           phase_q, phase_d;
    logic signed [DW-1:0] sample_q, sample_d;
    logic [15:0]          count_q, count_d;
    logic                 overrun_q, overrun_d;

    logic strobe_ok;
    assign strobe_ok = bus.in_strobe & bus.enable;

    // State register and datapath registers, cleared by the synchronous reset.
    always_ff @(posedge clk_en) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            sample_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            sample_q  <= sample_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: accept in IDLE, shift once, step the phases, wait for ack.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        sample_d  = sample_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        // A strobe outside IDLE cannot be stored; the sample is lost.
        if (strobe_ok && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (strobe_ok) begin
                    sample_d = bus.in_sample;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                phase_d = '0;
                state_d = MAC;
            end
            MAC: begin
                if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
                    state_d = DONE;
                end else begin
                    phase_d = phase_q + 6'd1;
                end
            end
            DONE: begin
                // Enable is deliberately not consulted: a started sample
                // always runs to completion.
                if (bus.out_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.shift_en  = 1'b0;
        bus.phase     = '0;
        bus.tap_a     = '0;
        bus.tap_b     = '0;
        bus.acc_clear = 1'b0;
        bus.acc_en    = 1'b0;
        bus.center    = 1'b0;
        bus.out_valid = 1'b0;

        if (!reset) begin
            case (state_q)
                IDLE: bus.in_ready = 1'b1;
                LOAD: bus.shift_en = 1'b1;
                MAC: begin
                    bus.acc_en    = 1'b1;
                    bus.phase     = phase_q;
                    bus.tap_a     = {1'b0, phase_q};
                    bus.tap_b     = LAST_TAP - {1'b0, phase_q};
                    bus.acc_clear = (phase_q == '0);
                    bus.center    = (phase_q == LAST_PHASE);
                end
                DONE: bus.out_valid = 1'b1;
                default: bus.in_ready = 1'b0;
            endcase
        end
    end

    assign bus.shift_data   = sample_q;
    assign bus.overrun      = overrun_q;
    assign bus.sample_count = count_q;

endmodule

// File: doc/filterbank_sequencer.md
FILTERBANK_SEQUENCER -- requirements
Module: filterbank_sequencer

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_TAPS, default 119, giving the delay-line length.
REQ-002 The block SHALL have parameter NUM_PHASES, default 60, giving the MAC phases per sample, equal to (NUM_TAPS+1)/2 for a symmetric fold.
REQ-003 The block SHALL have parameter DW, default 15, giving the sample width (sfix15_En14).

Ports:
REQ-004 clk_en  input  1  clock; all state SHALL change on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  when 1, new samples may be accepted.
REQ-007 in_strobe  input  1  one-cycle pulse marking a valid in_sample; the source has no backpressure.
REQ-008 in_sample  input  DW  input sample, signed.
REQ-009 out_ready  input  1  downstream accepts the filterbank results.
REQ-010 in_ready  output  1  high only in IDLE.
REQ-011 shift_en  output  1  one-cycle delay-line shift pulse.
REQ-012 shift_data  output  DW  sample to load into delay-line position 0.
REQ-013 phase  output  6  current MAC phase.
REQ-014 tap_a  output  7  lower tap index of the symmetric pair.
REQ-015 tap_b  output  7  upper tap index of the symmetric pair.
REQ-016 acc_clear  output  1  accumulators load instead of add.
REQ-017 acc_en  output  1  accumulators update.
REQ-018 center  output  1  center tap; add once, not pair-summed.
REQ-019 out_valid  output  1  all 16 filter outputs are valid.
REQ-020 overrun  output  1  sticky flag; a sample was dropped.
REQ-021 sample_count  output  16  count of completed output handshakes.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, LOAD, MAC, DONE.
REQ-023 IDLE SHALL drive in_ready=1 and go to LOAD on in_strobe&enable, capturing in_sample into an internal sample register that same edge.
REQ-024 LOAD SHALL last exactly 1 cycle, drive shift_en=1 with shift_data=sample register, and go to MAC with phase=0.
REQ-025 MAC SHALL drive acc_en=1, tap_a=phase, tap_b=NUM_TAPS-1-phase, acc_clear=(phase==0) and center=(phase==NUM_PHASES-1).
REQ-026 In MAC, phase SHALL increment by 1 per cycle and, after phase NUM_PHASES-1, the FSM SHALL go to DONE.
REQ-027 DONE SHALL hold out_valid=1 until out_ready=1, then go to IDLE and increment sample_count, which wraps from 0xFFFF to 0.
REQ-028 Outside their defined conditions, shift_en, acc_en, acc_clear, center and out_valid SHALL be 0.
REQ-029 Outside MAC, phase, tap_a and tap_b SHALL be 0.
REQ-030 Latency: for in_strobe accepted in cycle T, shift_en SHALL be high at T+1, MAC SHALL span T+2..T+61, and out_valid SHALL first be high at T+62, so minimum sample spacing is 63 cycles.
REQ-031 An in_strobe while the state is not IDLE and enable=1 SHALL set overrun and drop the sample, leaving the sample register and FSM undisturbed.
REQ-032 An in_strobe while enable=0 SHALL be ignored in all states and SHALL NOT set overrun.
REQ-033 Deasserting enable mid-operation SHALL NOT abort; the current sample SHALL complete through DONE.
REQ-034 If in_strobe and out_ready are both high in DONE, the strobe SHALL count as overrun and DONE→IDLE SHALL still occur.
REQ-035 out_ready SHALL be ignored outside DONE.
REQ-036 At the center phase, tap_a and tap_b SHALL both equal NUM_PHASES-1 (59).

Reset
REQ-037 reset=1 SHALL force IDLE, and set phase, tap_a, tap_b, shift_data, the sample register, sample_count and overrun to 0.
REQ-038 During reset=1, shift_en, acc_en, acc_clear, center and out_valid SHALL be 0, and in_ready SHALL be 0.
REQ-039 In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-040 Reset asserted during any state, including mid-MAC, SHALL abort immediately with no shift_en or out_valid emitted for the aborted sample.
REQ-041 reset SHALL take priority over in_strobe and out_ready in the same cycle.

Verification
REQ-042 enable=1, in_strobe at T with in_sample=0x1234, out_ready=1 -> shift_en=1 and shift_data=0x1234 at T+1; acc_clear only at T+2; tap_a/tap_b run 0/118..59/59 over T+2..T+61 with center only at T+61; out_valid at T+62; sample_count=1 and in_ready=1 at T+63.
REQ-043 A second in_strobe at T+30 -> overrun=1 from T+31 onward; shift_data stays 0x1234; out_valid still at T+62.
REQ-044 out_ready=0 until T+70 -> out_valid held T+62..T+70; IDLE at T+71.
REQ-045 Reset asserted at T+40 (mid-MAC) -> phase=0, acc_en=0 and overrun=0 next cycle; no out_valid; in_ready=1 after release.
REQ-046 enable=0 with an in_strobe -> no shift_en and overrun stays 0.
REQ-047 65536 back-to-back samples with 63-cycle spacing -> sample_count wraps to 0 and overrun stays 0.
